// File: rtl/memorydata_arbiter_pkg.sv
// Shared constants for the memorydata arbiter: FSM state codes and default
// bus widths. Imported by the interface, the top level and the testbench.
package memarb_pkg;

  // Default widths match the memorydata block (256 x 8).
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Sequencer states. Kept as plain 2-bit constants so the encoding is
  // visible on waveforms and stable across tool flows.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/memorydata_arbiter_if.sv
// Bundle of the two requester ports and the memorydata-side strobes.
// The arbiter connects through the slave modport; the environment that
// hosts the requesters and the memory uses the master modport.
interface memorydata_arbiter_if
  import memarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Requester 0: CPU load/store unit.
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;

  // Requester 1: program/data loader.
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;

  // Shared read result.
  logic [DATA_W-1:0] rdata;

  // memorydata side.
  logic              mem_Rm;
  logic              mem_Wm;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_RegVal;
  logic [DATA_W-1:0] mem_Data_out;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  done0, done1, rdata,
    input  mem_Rm, mem_Wm, mem_address, mem_RegVal,
    output mem_Data_out
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output done0, done1, rdata,
    output mem_Rm, mem_Wm, mem_address, mem_RegVal,
    input  mem_Data_out
  );

endinterface

// File: rtl/memorydata_arbiter_rr_arbiter2.sv
// Combinational two-way pick. `last` is the index of the requester served
// most recently; with rr_en set, a tie goes to the other one, otherwise a
// tie always goes to requester 0.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // One-hot grant from the current request pair.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/memorydata_arbiter.sv
// Two-port arbiter/sequencer in front of the memorydata block. Each transfer
// walks IDLE -> ACCESS -> DONE: the winner and its command are captured on
// the IDLE edge, the memory is strobed for one cycle, and the winner sees a
// one-cycle done pulse. All outputs come straight from flops.
module memorydata_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit RR     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  memorydata_arbiter_if.slave  bus
);

  // Sequencer and captured command.
  logic [1:0]        state_q, state_d;
  logic              gnt_idx_q, gnt_idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Read result and arbitration history.
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              last_q, last_d;

  // Registered outputs.
  logic              rm_q, rm_d;
  logic              wm_q, wm_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] regval_q, regval_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;

  // Arbitration inputs/outputs and the winner's command.
  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec = {bus.req1, bus.req0};

  rr_arbiter2 u_arb (
    .req   (req_vec),
    .last  (last_q),
    .rr_en (RR),
    .gnt   (gnt)
  );

  // Mux the winning requester's command onto the capture path.
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (gnt[1]) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // Next state, command capture, read-data latch and last-grant update.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d   = ACCESS;
          gnt_idx_d = gnt[1];
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
        end
      end
      ACCESS: begin
        state_d = DONE;
        last_d  = gnt_idx_q;
        if (!we_q) begin
          rdata_d = bus.mem_Data_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode what the outputs must show in the state being entered.
  always_comb begin
    rm_d     = 1'b0;
    wm_d     = 1'b0;
    maddr_d  = '0;
    regval_d = '0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    if (state_d == ACCESS) begin
      rm_d     = !we_d;
      wm_d     = we_d;
      maddr_d  = addr_d;
      regval_d = we_d ? wdata_d : '0;
    end
    if (state_d == DONE) begin
      done0_d = !gnt_idx_d;
      done1_d = gnt_idx_d;
    end
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_idx_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      last_q    <= 1'b1;
      rm_q      <= 1'b0;
      wm_q      <= 1'b0;
      maddr_q   <= '0;
      regval_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      last_q    <= last_d;
      rm_q      <= rm_d;
      wm_q      <= wm_d;
      maddr_q   <= maddr_d;
      regval_q  <= regval_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  assign bus.mem_Rm      = rm_q;
  assign bus.mem_Wm      = wm_q;
  assign bus.mem_address = maddr_q;
  assign bus.mem_RegVal  = regval_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_memorydata_arbiter.sv
// Bench for memorydata_arbiter: a round-robin instance and a fixed-priority
// instance, each with a small memorydata model behind it.
module tb_memorydata_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic memClear;

  int vecCount = 0;
  int missCount = 0;

  memorydata_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  memorydata_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busF ();

  memorydata_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  memorydata_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b0)) dutF (
    .clk   (clk),
    .reset (reset),
    .bus   (busF)
  );

  always #5 clk = ~clk;

  // memorydata models: combinational read, write on the rising edge.
  logic [DW-1:0] memArr  [256];
  logic [DW-1:0] memArrF [256];

  assign bus.mem_Data_out  = bus.mem_Rm  ? memArr[bus.mem_address]   : '0;
  assign busF.mem_Data_out = busF.mem_Rm ? memArrF[busF.mem_address] : '0;

  // Memory write ports, with a one-shot clear at the start of the run.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) begin
        memArr[i]  <= '0;
        memArrF[i] <= '0;
      end
    end else begin
      if (bus.mem_Wm)  memArr[bus.mem_address]   <= bus.mem_RegVal;
      if (busF.mem_Wm) memArrF[busF.mem_address] <= busF.mem_RegVal;
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input int p, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic doneOf(input int p);
    return (p == 0) ? bus.done0 : bus.done1;
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transfer on the round-robin instance, checked cycle by cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    driveReq(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    checkOutput($sformatf("v%0d_access_strobes", idx), {bus.mem_Rm, bus.mem_Wm}, v.we ? 2'b01 : 2'b10);
    checkOutput($sformatf("v%0d_access_addr", idx), bus.mem_address, v.addr);
    checkOutput($sformatf("v%0d_access_regval", idx), bus.mem_RegVal, v.we ? v.wdata : 8'h00);
    checkOutput($sformatf("v%0d_access_nodone", idx), {bus.done1, bus.done0}, 2'b00);
    @(negedge clk);
    checkOutput($sformatf("v%0d_done", idx), {bus.done1, bus.done0}, (v.port == 1) ? 2'b10 : 2'b01);
    checkOutput($sformatf("v%0d_done_strobes", idx), {bus.mem_Rm, bus.mem_Wm}, 2'b00);
    checkOutput($sformatf("v%0d_rdata", idx), bus.rdata, v.expRdata);
    driveReq(v.port, 1'b0, v.we, v.addr, v.wdata);
    @(negedge clk);
    checkOutput($sformatf("v%0d_idle_done", idx), {bus.done1, bus.done0, bus.mem_Rm, bus.mem_Wm}, 4'b0000);
    checkOutput($sformatf("v%0d_idle_addr", idx), bus.mem_address, 8'h00);
  endtask

  // Reference model state for the random phase.
  bit         outst  [2];
  int         raised [2];
  logic       weR    [2];
  logic [7:0] addrR  [2];
  logic [7:0] wdR    [2];
  logic [7:0] refMem [16];
  int         issued, served, lastServed, cyc;
  logic [7:0] lastRead;
  logic       pRm, pWm;
  logic [7:0] pAddr, pReg;

  // One cycle of random traffic: score completions, then let idle agents issue.
  task automatic randomCycle(input bit allowNew);
    @(negedge clk);
    cyc++;
    checkOutput("rnd_rm_wm_exclusive", bus.mem_Rm & bus.mem_Wm, 1'b0);
    checkOutput("rnd_single_done", bus.done0 & bus.done1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      if (doneOf(p)) begin
        checkOutput($sformatf("rnd_done%0d_owed", p), outst[p], 1'b1);
        if (outst[p]) begin
          checkOutput("rnd_latency", (cyc - raised[p]) >= 2, 1'b1);
          if (outst[1-p] && raised[1-p] <= cyc - 2)
            checkOutput("rnd_rr_winner", p, 1 - lastServed);
          checkOutput("rnd_access_strobes", {pRm, pWm}, weR[p] ? 2'b01 : 2'b10);
          checkOutput("rnd_access_addr", pAddr, addrR[p]);
          checkOutput("rnd_access_regval", pReg, weR[p] ? wdR[p] : 8'h00);
          checkOutput("rnd_done_strobes", {bus.mem_Rm, bus.mem_Wm}, 2'b00);
          if (weR[p]) begin
            checkOutput("rnd_rdata_hold_on_write", bus.rdata, lastRead);
            refMem[addrR[p][3:0]] = wdR[p];
          end else begin
            checkOutput("rnd_read_data", bus.rdata, refMem[addrR[p][3:0]]);
            lastRead = refMem[addrR[p][3:0]];
          end
          lastServed = p;
          outst[p] = 1'b0;
          served++;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (outst[p]) begin
        checkOutput($sformatf("rnd_wait_bound%0d", p), (cyc - raised[p]) <= 12, 1'b1);
        if ((cyc - raised[p]) > 12) outst[p] = 1'b0;
      end
    end
    pRm   = bus.mem_Rm;
    pWm   = bus.mem_Wm;
    pAddr = bus.mem_address;
    pReg  = bus.mem_RegVal;
    for (int p = 0; p < 2; p++) begin
      if (!outst[p] && allowNew && $urandom_range(0, 2) == 0) begin
        outst[p]  = 1'b1;
        raised[p] = cyc;
        weR[p]    = 1'($urandom_range(0, 1));
        addrR[p]  = {4'h8, 4'($urandom_range(0, 15))};
        wdR[p]    = 8'($urandom);
        issued++;
      end
      driveReq(p, outst[p], weR[p], addrR[p], wdR[p]);
    end
  endtask

  vec_t vecs [10];

  initial begin
    int gap;
    int d0Cnt;
    int d1Cnt;
    logic [1:0] firstDone;

    vecs[0] = vec_t'{0, 1'b1, 8'h00, 8'h01, 8'h00};
    vecs[1] = vec_t'{0, 1'b0, 8'h00, 8'h00, 8'h01};
    vecs[2] = vec_t'{1, 1'b1, 8'h3F, 8'hA5, 8'h01};
    vecs[3] = vec_t'{1, 1'b0, 8'h3F, 8'h00, 8'hA5};
    vecs[4] = vec_t'{0, 1'b1, 8'hFF, 8'h5A, 8'hA5};
    vecs[5] = vec_t'{1, 1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[6] = vec_t'{0, 1'b0, 8'h3F, 8'h00, 8'hA5};
    vecs[7] = vec_t'{1, 1'b1, 8'h00, 8'hC3, 8'hA5};
    vecs[8] = vec_t'{0, 1'b0, 8'h00, 8'h00, 8'hC3};
    vecs[9] = vec_t'{1, 1'b0, 8'h80, 8'h00, 8'h00};

    reset = 1'b1;
    memClear = 1'b1;
    driveReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveReq(1, 1'b0, 1'b0, 8'h00, 8'h00);
    busF.req0 = 1'b0; busF.we0 = 1'b0; busF.addr0 = '0; busF.wdata0 = '0;
    busF.req1 = 1'b0; busF.we1 = 1'b0; busF.addr1 = '0; busF.wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_strobes_done", {bus.done1, bus.done0, bus.mem_Rm, bus.mem_Wm}, 4'b0000);
    checkOutput("reset_addr", bus.mem_address, 8'h00);
    checkOutput("reset_regval", bus.mem_RegVal, 8'h00);
    checkOutput("reset_rdata", bus.rdata, 8'h00);
    checkOutput("reset_fp_outputs", {busF.done1, busF.done0, busF.mem_Rm, busF.mem_Wm, busF.rdata}, 12'h000);
    memClear = 1'b0;
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    $display("[TB] simultaneous requests, round-robin");
    doReset();
    @(negedge clk);
    driveReq(0, 1'b1, 1'b1, 8'h03, 8'h23);
    driveReq(1, 1'b1, 1'b1, 8'h09, 8'h07);
    firstDone = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      firstDone = {bus.done1, bus.done0};
      if (firstDone != 2'b00) break;
    end
    checkOutput("tie_first_winner", firstDone, 2'b01);
    driveReq(0, 1'b0, 1'b1, 8'h03, 8'h23);
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gap++;
      if (bus.done1) break;
    end
    checkOutput("tie_second_gap", gap, 3);
    driveReq(1, 1'b0, 1'b1, 8'h09, 8'h07);
    applyStimulus(vec_t'{0, 1'b0, 8'h03, 8'h00, 8'h23}, 20);
    applyStimulus(vec_t'{1, 1'b0, 8'h09, 8'h00, 8'h07}, 21);

    $display("[TB] late request and input change after capture");
    doReset();
    @(negedge clk);
    driveReq(0, 1'b1, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    checkOutput("late_access_rm", {bus.mem_Rm, bus.mem_Wm}, 2'b10);
    driveReq(0, 1'b1, 1'b0, 8'h09, 8'h00);
    driveReq(1, 1'b1, 1'b1, 8'h10, 8'h44);
    @(negedge clk);
    checkOutput("late_done0", {bus.done1, bus.done0}, 2'b01);
    checkOutput("late_rdata_captured_addr", bus.rdata, 8'h23);
    driveReq(0, 1'b0, 1'b0, 8'h09, 8'h00);
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gap++;
      if (bus.done1) break;
    end
    checkOutput("late_done1_gap", gap, 3);
    driveReq(1, 1'b0, 1'b1, 8'h10, 8'h44);
    applyStimulus(vec_t'{1, 1'b0, 8'h10, 8'h00, 8'h44}, 30);

    $display("[TB] reset during ACCESS");
    @(negedge clk);
    driveReq(0, 1'b1, 1'b0, 8'h09, 8'h00);
    @(negedge clk);
    checkOutput("rst_mid_access_rm", bus.mem_Rm, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_outputs", {bus.done1, bus.done0, bus.mem_Rm, bus.mem_Wm}, 4'b0000);
    checkOutput("rst_mid_rdata", bus.rdata, 8'h00);
    reset = 1'b0;
    driveReq(0, 1'b0, 1'b0, 8'h09, 8'h00);
    @(negedge clk);
    checkOutput("rst_mid_no_late_done", {bus.done1, bus.done0}, 2'b00);

    $display("[TB] fixed priority");
    @(negedge clk);
    busF.req0 = 1'b1; busF.we0 = 1'b1; busF.addr0 = 8'h20; busF.wdata0 = 8'h11;
    busF.req1 = 1'b1; busF.we1 = 1'b0; busF.addr1 = 8'h20; busF.wdata1 = 8'h00;
    d0Cnt = 0;
    d1Cnt = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (busF.done0) d0Cnt++;
      if (busF.done1) d1Cnt++;
    end
    checkOutput("fp_done0_count", d0Cnt, 6);
    checkOutput("fp_done1_count", d1Cnt, 0);
    busF.req0 = 1'b0;
    gap = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gap++;
      if (busF.done1) break;
    end
    checkOutput("fp_req1_after_drop_gap", gap, 2);
    checkOutput("fp_req1_rdata", busF.rdata, 8'h11);
    busF.req1 = 1'b0;

    $display("[TB] random traffic");
    doReset();
    for (int p = 0; p < 2; p++) begin
      outst[p] = 1'b0; raised[p] = 0; weR[p] = 1'b0; addrR[p] = 8'h80; wdR[p] = 8'h00;
    end
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    issued = 0; served = 0; lastServed = 1; cyc = 0; lastRead = 8'h00;
    pRm = 1'b0; pWm = 1'b0; pAddr = 8'h00; pReg = 8'h00;
    for (int i = 0; i < 1000; i++) randomCycle(1'b1);
    for (int i = 0; i < 20; i++) randomCycle(1'b0);
    checkOutput("rnd_all_served", served, issued);
    checkOutput("rnd_none_pending", {outst[1], outst[0]}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
